// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the ALU issue logic and the ALU itself.
//   - ALU control codes (4-bit alu_control)
//   - RV32I opcode and funct7 constants
//   - issue packet carried from decode through the skid buffer to execute
//   - f3_decode: funct3 -> ALU code for the register/immediate integer ops
package alu_pkg;

   localparam int XLEN_P  = 32;
   localparam int RF_AW_P = 5;

   typedef enum logic [3:0] {
      ALU_OR    = 4'b0001,
      ALU_ADD   = 4'b0010,
      ALU_XOR   = 4'b0011,
      ALU_SLL   = 4'b0100,
      ALU_SRL   = 4'b0101,
      ALU_SUB   = 4'b0110,
      ALU_SLTU  = 4'b0111,
      ALU_SRA   = 4'b1000,
      ALU_NOR   = 4'b1100,
      ALU_AND   = 4'b1110,
      ALU_PASSB = 4'b1111
   } alu_ctrl_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [XLEN_P-1:0]  a;
      logic [XLEN_P-1:0]  b;
      logic [3:0]         alu_control;
      logic [RF_AW_P-1:0] rd;
      logic               we;
      logic               illegal;
   } issue_pkt_t;

   typedef struct packed {
      logic       legal;
      logic [3:0] ctrl;
   } f3_res_t;

   // funct3 map for the base (funct7=0) integer ops. SLT (010) has no ALU
   // support and comes back as not legal.
   function automatic f3_res_t f3_decode(input logic [2:0] funct3);
      f3_res_t r;
      r.legal = 1'b1;
      r.ctrl  = ALU_ADD;
      case (funct3)
         3'b000:  r.ctrl = ALU_ADD;
         3'b001:  r.ctrl = ALU_SLL;
         3'b011:  r.ctrl = ALU_SLTU;
         3'b100:  r.ctrl = ALU_XOR;
         3'b101:  r.ctrl = ALU_SRL;
         3'b110:  r.ctrl = ALU_OR;
         3'b111:  r.ctrl = ALU_AND;
         default: r.legal = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// alu_issue_skid: 2-entry skid buffer (output register + skid register).
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   upstream handshake; in_ready is registered (= !skid full)
//   in_data[W]          packet in
//   out_valid/out_ready downstream handshake
//   out_data[W]         packet out, held while stalled
module alu_issue_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         or_valid_q, or_valid_d;
   logic [W-1:0] or_data_q,  or_data_d;
   logic         sr_valid_q, sr_valid_d;
   logic [W-1:0] sr_data_q,  sr_data_d;
   logic         in_ready_q, in_ready_d;
   logic         accept, drain;

   assign accept = in_valid & in_ready_q;
   assign drain  = or_valid_q & out_ready;

   always_comb begin
      or_valid_d = or_valid_q;
      or_data_d  = or_data_q;
      sr_valid_d = sr_valid_q;
      sr_data_d  = sr_data_q;
      if (drain) begin
         or_valid_d = 1'b0;
      end
      if (sr_valid_q) begin
         // in_ready is low whenever the skid entry is full, so no accept here
         if (drain) begin
            or_valid_d = 1'b1;
            or_data_d  = sr_data_q;
            sr_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!or_valid_q || out_ready) begin
            or_valid_d = 1'b1;
            or_data_d  = in_data;
         end else begin
            sr_valid_d = 1'b1;
            sr_data_d  = in_data;
         end
      end
      in_ready_d = !sr_valid_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         or_valid_q <= 1'b0;
         or_data_q  <= '0;
         sr_valid_q <= 1'b0;
         sr_data_q  <= '0;
         in_ready_q <= 1'b0;
      end else begin
         or_valid_q <= or_valid_d;
         or_data_q  <= or_data_d;
         sr_valid_q <= sr_valid_d;
         sr_data_q  <= sr_data_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = or_valid_q;
   assign out_data  = or_data_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes RV32I ALU-class instructions into ALU control and
// operands, then hands the packet to execute through a 2-entry skid buffer.
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_valid/in_ready                instruction handshake
//   in_instr, in_pc, in_rs1_data, in_rs2_data   instruction and operand values
//   out_valid/out_ready              issue handshake
//   out_a, out_b, out_alu_control, out_rd, out_we, out_illegal   issue packet
//   perf_issued, perf_stall          only with ALU_ISSUE_PERF_EN defined:
//                                    output transfers / stalled cycles (wrap)
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int RF_AW = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_rs1_data,
   input  logic [XLEN-1:0]  in_rs2_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_a,
   output logic [XLEN-1:0]  out_b,
   output logic [3:0]       out_alu_control,
   output logic [RF_AW-1:0] out_rd,
   output logic             out_we,
   output logic             out_illegal
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [31:0]      perf_issued,
   output logic [31:0]      perf_stall
`endif
);

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [31:0] i_imm, u_imm;
   logic        legal;
   f3_res_t     f3_res;
   issue_pkt_t  dec_pkt, out_pkt;
   logic        unused_rs_idx;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign i_imm  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign u_imm  = {in_instr[31:12], 12'b0};
   assign f3_res = f3_decode(funct3);

   // Register indices are resolved by the register-file read upstream.
   assign unused_rs_idx = ^in_instr[19:15];

   always_comb begin
      dec_pkt             = '0;
      dec_pkt.alu_control = ALU_ADD;
      dec_pkt.rd          = in_instr[11:7];
      legal               = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_pkt.a  = in_rs1_data;
            dec_pkt.b  = in_rs2_data;
            dec_pkt.we = 1'b1;
            if (funct7 == F7_BASE) begin
               legal               = f3_res.legal;
               dec_pkt.alu_control = f3_res.ctrl;
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               legal               = 1'b1;
               dec_pkt.alu_control = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               legal               = 1'b1;
               dec_pkt.alu_control = ALU_SRA;
            end
         end
         OPC_OP_IMM: begin
            dec_pkt.a  = in_rs1_data;
            dec_pkt.b  = i_imm;
            dec_pkt.we = 1'b1;
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               // shifts: upper immediate bits select the shift flavour
               dec_pkt.b = {27'b0, in_instr[24:20]};
               if (funct7 == F7_BASE) begin
                  legal               = 1'b1;
                  dec_pkt.alu_control = f3_res.ctrl;
               end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                  legal               = 1'b1;
                  dec_pkt.alu_control = ALU_SRA;
               end
            end else begin
               legal               = f3_res.legal;
               dec_pkt.alu_control = f3_res.ctrl;
            end
         end
         OPC_LUI: begin
            legal               = 1'b1;
            dec_pkt.b           = u_imm;
            dec_pkt.alu_control = ALU_PASSB;
            dec_pkt.we          = 1'b1;
         end
         OPC_AUIPC: begin
            legal               = 1'b1;
            dec_pkt.a           = in_pc;
            dec_pkt.b           = u_imm;
            dec_pkt.we          = 1'b1;
         end
         OPC_BRANCH: begin
            // branch compare only; the rd field holds immediate bits
            legal               = (funct3 == 3'b000) || (funct3 == 3'b001);
            dec_pkt.rd          = '0;
            dec_pkt.a           = in_rs1_data;
            dec_pkt.b           = in_rs2_data;
            dec_pkt.alu_control = ALU_SUB;
         end
         default: ;
      endcase
      if (!legal) begin
         dec_pkt.a           = '0;
         dec_pkt.b           = '0;
         dec_pkt.alu_control = ALU_ADD;
         dec_pkt.we          = 1'b0;
      end
      if (dec_pkt.rd == '0) begin
         dec_pkt.we = 1'b0;
      end
      dec_pkt.illegal = !legal;
   end

   alu_issue_skid #(
      .W($bits(issue_pkt_t))
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (dec_pkt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_pkt)
   );

   assign out_a           = out_pkt.a;
   assign out_b           = out_pkt.b;
   assign out_alu_control = out_pkt.alu_control;
   assign out_rd          = out_pkt.rd;
   assign out_we          = out_pkt.we;
   assign out_illegal     = out_pkt.illegal;

`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] perf_issued_q, perf_stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issued_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         if (out_valid && out_ready) perf_issued_q <= perf_issued_q + 32'd1;
         if (out_valid && !out_ready) perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_issued = perf_issued_q;
   assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

   logic        clk, rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
   logic [31:0] out_a, out_b;
   logic [3:0]  out_alu_control;
   logic [4:0]  out_rd;
   logic        out_we, out_illegal;
`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] perf_issued, perf_stall;
   int unsigned exp_issued, exp_stall;
`endif

   alu_issue_ctrl dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
      .out_alu_control(out_alu_control), .out_rd(out_rd), .out_we(out_we),
      .out_illegal(out_illegal)
`ifdef ALU_ISSUE_PERF_EN
      , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a, b;
      logic [3:0]  ctl;
      logic [4:0]  rd;
      logic        we, ill;
   } exp_t;

   exp_t sb[$];
   int n_chk = 0, n_err = 0, n_out = 0;
   logic        prev_stall = 1'b0;
   logic [79:0] held;

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   // Reference: mnemonic-level meaning of each instruction class.
   function automatic exp_t ref_decode(input logic [31:0] ins, pc, r1, r2);
      exp_t e;
      logic [6:0] op = ins[6:0];
      logic [2:0] f3 = ins[14:12];
      logic [6:0] f7 = ins[31:25];
      logic [3:0] base [8] = '{4'd2, 4'd4, 4'd0, 4'd7, 4'd3, 4'd5, 4'd1, 4'd14};
      logic ok = 1'b0;
      e.a = 0; e.b = 0; e.ctl = 4'd2; e.we = 1'b1; e.rd = ins[11:7];
      if (op == 7'h33) begin
         e.a = r1; e.b = r2;
         if (f7 == 0 && f3 != 3'd2) begin ok = 1; e.ctl = base[f3]; end
         if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1; e.ctl = 4'd6; end
         if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; e.ctl = 4'd8; end
      end else if (op == 7'h13) begin
         e.a = r1;
         if (f3 == 3'd1 || f3 == 3'd5) begin
            e.b = 32'(ins[24:20]);
            if (f7 == 0) begin ok = 1; e.ctl = base[f3]; end
            if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; e.ctl = 4'd8; end
         end else begin
            e.b = 32'($signed(ins[31:20]));
            ok = (f3 != 3'd2); e.ctl = base[f3];
         end
      end else if (op == 7'h37) begin
         ok = 1; e.b = ins & 32'hFFFFF000; e.ctl = 4'd15;
      end else if (op == 7'h17) begin
         ok = 1; e.a = pc; e.b = ins & 32'hFFFFF000;
      end else if (op == 7'h63) begin
         e.rd = 0; e.we = 0; e.a = r1; e.b = r2; e.ctl = 4'd6;
         ok = (f3 <= 3'd1);
      end
      if (!ok) begin e.a = 0; e.b = 0; e.ctl = 4'd2; e.we = 0; end
      if (e.rd == 0) e.we = 0;
      e.ill = !ok;
      return e;
   endfunction

   // One clock: score what transfers at the coming edge, then advance.
   task automatic step();
      exp_t e;
      logic [79:0] cur;
      cur = {out_a, out_b, out_alu_control, out_rd, out_we, out_illegal, 9'd0};
      if (prev_stall) begin
         chk("hold_valid", 80'(out_valid), 80'd1);
         chk("hold_data", cur, held);
      end
      prev_stall = out_valid && !out_ready;
      held = cur;
      if (out_valid && out_ready) begin
         n_out++;
         if (sb.size() == 0) chk("sb_underflow", 80'd1, 80'd0);
         else begin
            e = sb.pop_front();
            chk("pkt_ab", {16'd0, out_a, out_b}, {16'd0, e.a, e.b});
            chk("pkt_ctl", {out_alu_control, out_rd, out_we, out_illegal},
                {e.ctl, e.rd, e.we, e.ill});
         end
      end
      if (in_valid && in_ready) sb.push_back(ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data));
`ifdef ALU_ISSUE_PERF_EN
      if (out_valid && out_ready) exp_issued++;
      if (out_valid && !out_ready) exp_stall++;
`endif
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] ins, pc, r1, r2);
      in_valid = 1'b1; in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
   endtask

   // Issue one instruction alone with out_ready=1, leave it visible on the outputs.
   task automatic issue_one(input logic [31:0] ins, pc, r1, r2);
      out_ready = 1'b1;
      drive(ins, pc, r1, r2);
      step();
      in_valid = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [31:0] a, b, input logic [3:0] ctl,
                          input logic [4:0] rd, input logic we, ill);
      chk({tag, "_v"}, 80'(out_valid), 80'd1);
      chk({tag, "_ab"}, {16'd0, out_a, out_b}, {16'd0, a, b});
      chk({tag, "_ctl"}, {out_alu_control, out_rd, out_we, out_illegal}, {ctl, rd, we, ill});
   endtask

   function automatic logic [31:0] gen_instr();
      logic [6:0] f7, op;
      logic [1:0] p = 2'($urandom_range(0, 3));
      int k = $urandom_range(0, 7);
      f7 = (p == 2) ? 7'h20 : (p == 3) ? 7'($urandom) : 7'h00;
      case (k)
         0, 1:    op = 7'h33;
         2, 3:    op = 7'h13;
         4:       op = 7'h37;
         5:       op = 7'h17;
         6:       op = 7'h63;
         default: return $urandom;
      endcase
      return r_type(f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), op);
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 80'(out_valid), 80'd0);
      chk("rst_in_ready", 80'(in_ready), 80'd0);
      sb.delete();
      prev_stall = 1'b0;
`ifdef ALU_ISSUE_PERF_EN
      exp_issued = 0; exp_stall = 0;
`endif
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("post_rst_in_ready", 80'(in_ready), 80'd1);
      chk("post_rst_out_valid", 80'(out_valid), 80'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int acc, cyc, n0;
      logic took;
      rst = 1'b1; in_valid = 0; out_ready = 0;
      in_instr = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0;
      @(negedge clk);
      chk("rst_data", {16'd0, out_a, out_b}, 80'd0);
      chk("rst_fields", {71'd0, out_alu_control, out_rd}, 80'd0);
      do_reset();

      // ADDI x5,x1,-1
      issue_one({12'hFFF, 5'd1, 3'd0, 5'd5, 7'h13}, 0, 32'h10, 0);
      chk_out("addi", 32'h10, 32'hFFFF_FFFF, 4'b0010, 5'd5, 1, 0);
      issue_one(r_type(7'h20, 5'd4, 5'd2, 3'd0, 5'd3, 7'h33), 0, 32'h8000_0000, 4);
      chk_out("sub", 32'h8000_0000, 4, 4'b0110, 5'd3, 1, 0);
      issue_one(r_type(7'h20, 5'd4, 5'd2, 3'd5, 5'd3, 7'h33), 0, 32'h8000_0000, 4);
      chk_out("sra", 32'h8000_0000, 4, 4'b1000, 5'd3, 1, 0);
      issue_one(r_type(7'h20, 5'd4, 5'd2, 3'd5, 5'd3, 7'h13), 0, 32'h8000_0000, 9);
      chk_out("srai", 32'h8000_0000, 4, 4'b1000, 5'd3, 1, 0);
      issue_one({20'hABCDE, 5'd7, 7'h37}, 0, 32'h55, 32'h66);
      chk_out("lui", 0, 32'hABCD_E000, 4'b1111, 5'd7, 1, 0);
      issue_one({20'h00001, 5'd9, 7'h17}, 32'h100, 0, 0);
      chk_out("auipc", 32'h100, 32'h1000, 4'b0010, 5'd9, 1, 0);
      issue_one(r_type(7'h00, 5'd3, 5'd2, 3'd2, 5'd1, 7'h33), 0, 32'h11, 32'h22);
      chk_out("slt", 0, 0, 4'b0010, 5'd1, 0, 1);
      issue_one({12'h004, 5'd2, 3'd2, 5'd6, 7'h03}, 0, 32'h11, 32'h22);
      chk_out("load", 0, 0, 4'b0010, 5'd6, 0, 1);
      issue_one(r_type(7'h00, 5'd3, 5'd2, 3'd1, 5'd0, 7'h63), 0, 32'h11, 32'h22);
      chk_out("bne", 32'h11, 32'h22, 4'b0110, 5'd0, 0, 0);
      issue_one(r_type(7'h00, 5'd3, 5'd2, 3'd0, 5'd0, 7'h33), 0, 32'h11, 32'h22);
      chk_out("add_x0", 32'h11, 32'h22, 4'b0010, 5'd0, 0, 0);
      step(); step();
      chk("idle_empty", 80'(sb.size()), 80'd0);

      // Backpressure: fill both entries, then drain in order.
      n0 = n_out;
      out_ready = 0;
      drive(r_type(0, 5'd2, 5'd1, 3'd0, 5'd1, 7'h33), 0, 1, 2); step();
      chk("stall1_ready", 80'(in_ready), 80'd1);
      drive(r_type(0, 5'd2, 5'd1, 3'd4, 5'd2, 7'h33), 0, 3, 4); step();
      chk("stall2_ready", 80'(in_ready), 80'd0);
      drive(r_type(0, 5'd2, 5'd1, 3'd6, 5'd3, 7'h33), 0, 5, 6); step();
      chk("stall3_ready", 80'(in_ready), 80'd0);
      chk("stall3_valid", 80'(out_valid), 80'd1);
      out_ready = 1; step();
      chk("drain1_ready", 80'(in_ready), 80'd1);
      step();
      in_valid = 0; step(); step();
      chk("drain_count", 80'(n_out - n0), 80'd3);
      chk("drain_empty", 80'(sb.size()), 80'd0);

      // Reset with two packets buffered.
      out_ready = 0;
      drive(r_type(0, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33), 0, 7, 8); step();
      drive(r_type(0, 5'd2, 5'd1, 3'd0, 5'd5, 7'h33), 0, 9, 10); step();
      in_valid = 0;
      do_reset();
      out_ready = 1; step(); step();
      chk("no_stale", 80'(out_valid), 80'd0);

      // Random streaming.
      acc = 0; cyc = 0; in_valid = 0;
      while (acc < 1000 && cyc < 20000) begin
         out_ready = ($urandom_range(0, 9) < 7);
         if (!in_valid && $urandom_range(0, 9) < 7)
            drive(gen_instr(), $urandom, $urandom, $urandom);
         took = in_valid && in_ready;
         step(); cyc++;
         if (took) begin acc++; in_valid = 0; end
      end
      if (acc < 1000) chk("rand_budget", 80'(acc), 80'd1000);
      in_valid = 0; out_ready = 1;
      for (int i = 0; i < 4; i++) step();
      chk("rand_empty", 80'(sb.size()), 80'd0);
`ifdef ALU_ISSUE_PERF_EN
      chk("perf_issued", 80'(perf_issued), 80'(exp_issued));
      chk("perf_stall", 80'(perf_stall), 80'(exp_stall));
`endif
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue-side counterpart of the processor's ALU.
- Accepts RV32I instructions with register operands over a valid/ready handshake and decodes them into the ALU's 4-bit alu_control code.
- Selects and forms operands A and B (register, immediate, PC, zero).
- Presents them registered to the execute stage through a 2-entry skid buffer, so both sides run at full throughput under backpressure.

Parameters:
XLEN, 32, datapath width of A/B/rs data/pc
RF_AW, 5, register index width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  block can accept this cycle
in_instr  input  32  RV32I instruction word
in_pc  input  XLEN  instruction PC
in_rs1_data  input  XLEN  rs1 value
in_rs2_data  input  XLEN  rs2 value
out_valid  output  1  issue packet valid
out_ready  input  1  execute stage accepts
out_a  output  XLEN  ALU operand A
out_b  output  XLEN  ALU operand B
out_alu_control  output  4  ALU operation code
out_rd  output  RF_AW  destination register
out_we  output  1  result writes rd
out_illegal  output  1  instruction not supported

Behaviour:
- Reset (async, rst=1): out_valid=0, in_ready=0, all out_* data=0, both skid entries empty. First cycle after release: in_ready=1.
- Handshake: a transfer occurs when valid&ready are both 1 in the same cycle. out_* are held stable while out_valid=1 and out_ready=0. in_ready comes from a flop (not combinational from out_ready) and equals !skid_full.
- Latency: instruction accepted in cycle N -> out_valid=1 in cycle N+1 if the output register is free.
- Skid buffer: output register (OR) plus skid register (SR).
  - Accept while OR is empty or draining -> write OR.
  - Accept while OR is stalled -> write SR; in_ready=0 next cycle.
  - OR drains while SR is full -> SR moves to OR; in_ready=1 next cycle.
  - Simultaneous accept and drain with SR empty -> new packet goes to OR.
  - Order is always preserved.
- ALU codes: OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLTU 0111, SRA 1000, NOR 1100, AND 1110, PASSB 1111.
- Decode, by opcode:
  - OP 0110011: A=rs1, B=rs2, we=1.
    - funct7=0000000: funct3 000 ADD, 001 SLL, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
    - funct7=0100000: only funct3 000 SUB and 101 SRA are legal.
  - OP-IMM 0010011: A=rs1, B=sign-extended instr[31:20], same funct3 map.
    - Shifts: B={27'b0,instr[24:20]}; instr[30]=1 with funct3 101 -> SRA.
    - Shifts with any other instr[31:25] pattern are illegal.
  - LUI 0110111: A=0, B={instr[31:12],12'b0}, PASSB, we=1.
  - AUIPC 0010111: A=pc, B={instr[31:12],12'b0}, ADD, we=1.
  - BRANCH 1100011, funct3 000/001: A=rs1, B=rs2, SUB, we=0, rd=0.
- Illegal: signed SLT/SLTI (funct3 010) is unsupported by the ALU and is flagged. Any other opcode or encoding is also flagged. Illegal response: illegal=1, we=0, alu_control=ADD, A=B=0.
- rd: instr[11:7] for all opcodes except BRANCH; we forced to 0 when rd=0.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- Defined: adds output ports perf_issued[31:0] and perf_stall[31:0].
  - perf_issued increments on each output transfer.
  - perf_stall increments each cycle with out_valid&!out_ready.
  - Both wrap at 2^32 and are cleared by rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg:
  - alu_control code constants (shared with the ALU).
  - RV32I opcode constants and funct7 constants.
  - Issue-packet struct {a, b, alu_control, rd, we, illegal}.
- Sub-module alu_issue_skid: generic-width 2-entry skid buffer that carries the packet. Decode is combinational in the parent, ahead of the skid.

Test Plan:
- Reset release, then ADDI x5,x1,-1 with rs1=0x10, out_ready=1 -> next cycle out_valid=1, A=0x10, B=0xFFFFFFFF, ctrl=0010, rd=5, we=1.
- SUB/SRA/SRAI x3,x2,4 with rs1=0x80000000 -> ctrl 0110 / 1000 / 1000; SRAI B=4.
- LUI x7,0xABCDE -> A=0, B=0xABCDE000, ctrl=1111. AUIPC with pc=0x100, imm 1 -> A=0x100, B=0x1000, ctrl=0010.
- Hold out_ready=0 and push 3 instructions -> two are buffered, in_ready=0 from the 3rd cycle. Release -> in-order drain over 2 cycles, in_ready returns to 1, no loss or duplication.
- SLT x1,x2,x3 and opcode 0000011 -> illegal=1, we=0, ctrl=0010, A=B=0.
- Assert rst mid-stall with 2 entries buffered -> out_valid=0 immediately; no stale packet after release. Random valid/ready streaming of 1000 ops matches a reference model.
